// File: rtl/register_writeback_queue.sv
// Writeback queue in front of the 8x16 register file.
// Holds pending writes, drains the head onto the file's single write port
// one entry per cycle, and gives decode a hazard and bypass lookup over
// every write that has not reached the file yet.
module register_writeback_queue #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enq_valid,
  output logic                    enq_ready,
  input  logic [ADDR_WIDTH-1:0]   enq_address,
  input  logic [DATA_WIDTH-1:0]   enq_data,
  input  logic                    rf_hold,
  output logic                    rf_load,
  output logic [ADDR_WIDTH-1:0]   rf_in_address,
  output logic [DATA_WIDTH-1:0]   rf_in_data,
  input  logic [ADDR_WIDTH-1:0]   query_address_a,
  input  logic [ADDR_WIDTH-1:0]   query_address_b,
  output logic                    hit_a,
  output logic                    hit_b,
  output logic [DATA_WIDTH-1:0]   bypass_data_a,
  output logic [DATA_WIDTH-1:0]   bypass_data_b,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];

  logic push;
  logic pop;

  // No same-cycle credit from a pop: a full queue refuses even while draining.
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign enq_ready = !full;
  assign count     = count_q;
  assign push      = enq_valid && enq_ready;
  assign rf_load   = !empty && !rf_hold;
  assign pop       = rf_load;

  assign rf_in_address = empty ? '0 : addr_q[rd_ptr_q];
  assign rf_in_data    = empty ? '0 : data_q[rd_ptr_q];

  // Next-state for pointers, occupancy count and per-entry valid bits.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (push) begin
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      valid_d[wr_ptr_q] = 1'b1;
    end
    if (pop) begin
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
      valid_d[rd_ptr_q] = 1'b0;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards queued writes without draining them.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Payload storage; contents are qualified by valid_q so no reset is needed.
  always_ff @(posedge clock) begin
    if (push) begin
      addr_q[wr_ptr_q] <= enq_address;
      data_q[wr_ptr_q] <= enq_data;
    end
  end

  // Walk oldest to youngest so the last match (youngest) wins.
  function automatic logic [DATA_WIDTH:0] lookup(input logic [ADDR_WIDTH-1:0] q);
    logic [PTR_W-1:0]    idx;
    logic [DATA_WIDTH:0] r;
    r = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PTR_W'(k);
      if (valid_q[idx] && (addr_q[idx] == q)) begin
        r = {1'b1, data_q[idx]};
      end
    end
    return r;
  endfunction

  // Hazard lookup for read port A.
  always_comb begin
    {hit_a, bypass_data_a} = lookup(query_address_a);
  end

  // Hazard lookup for read port B.
  always_comb begin
    {hit_b, bypass_data_b} = lookup(query_address_b);
  end

endmodule

// File: tb/tb_register_writeback_queue.sv
module tb_register_writeback_queue;

  logic        clock;
  logic        reset;
  logic        enq_valid;
  logic        enq_ready;
  logic [2:0]  enq_address;
  logic [15:0] enq_data;
  logic        rf_hold;
  logic        rf_load;
  logic [2:0]  rf_in_address;
  logic [15:0] rf_in_data;
  logic [2:0]  query_address_a;
  logic [2:0]  query_address_b;
  logic        hit_a;
  logic        hit_b;
  logic [15:0] bypass_data_a;
  logic [15:0] bypass_data_b;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  register_writeback_queue #(.DEPTH(4), .DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
    .clock(clock),
    .reset(reset),
    .enq_valid(enq_valid),
    .enq_ready(enq_ready),
    .enq_address(enq_address),
    .enq_data(enq_data),
    .rf_hold(rf_hold),
    .rf_load(rf_load),
    .rf_in_address(rf_in_address),
    .rf_in_data(rf_in_data),
    .query_address_a(query_address_a),
    .query_address_b(query_address_b),
    .hit_a(hit_a),
    .hit_b(hit_b),
    .bypass_data_a(bypass_data_a),
    .bypass_data_b(bypass_data_b),
    .count(count),
    .empty(empty),
    .full(full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        ev;
    logic [2:0]  ea;
    logic [15:0] ed;
    logic        hold;
    logic [2:0]  qa;
    logic [2:0]  qb;
    logic [2:0]  cnt;
    logic        emp;
    logic        ful;
    logic        rdy;
    logic        load;
    logic [2:0]  rfa;
    logic [15:0] rfd;
    logic        ha;
    logic        hb;
    logic [15:0] bpa;
    logic [15:0] bpb;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passes = 0;

  function automatic vec_t mkv(logic ev, logic [2:0] ea, logic [15:0] ed, logic hold,
                               logic [2:0] qa, logic [2:0] qb, logic [2:0] cnt,
                               logic emp, logic ful, logic rdy, logic load,
                               logic [2:0] rfa, logic [15:0] rfd, logic ha, logic hb,
                               logic [15:0] bpa, logic [15:0] bpb);
    vec_t v;
    v.ev = ev; v.ea = ea; v.ed = ed; v.hold = hold; v.qa = qa; v.qb = qb;
    v.cnt = cnt; v.emp = emp; v.ful = ful; v.rdy = rdy; v.load = load;
    v.rfa = rfa; v.rfd = rfd; v.ha = ha; v.hb = hb; v.bpa = bpa; v.bpb = bpb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [59:0] pack_out();
    return {count, empty, full, enq_ready, rf_load, rf_in_address, rf_in_data,
            hit_a, hit_b, bypass_data_a, bypass_data_b};
  endfunction

  function automatic logic [59:0] pack_exp(vec_t v);
    return {v.cnt, v.emp, v.ful, v.rdy, v.load, v.rfa, v.rfd, v.ha, v.hb, v.bpa, v.bpb};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [2:0]  log_a[$];
  logic [15:0] log_d[$];
  logic        drained;

  initial begin
    reset = 1'b0;
    enq_valid = 1'b0; enq_address = '0; enq_data = '0;
    rf_hold = 1'b1; query_address_a = '0; query_address_b = '0;

    // columns: ev ea ed hold qa qb | cnt empty full rdy load rfa rfd ha hb bpa bpb
    vecs.push_back(mkv(0,0,0,1,3,4,          0,1,0,1,0,0,0,0,0,0,0));
    vecs.push_back(mkv(1,3,'h1234,1,3,4,     0,1,0,1,0,0,0,0,0,0,0));
    vecs.push_back(mkv(0,0,0,1,3,4,          1,0,0,1,0,3,'h1234,1,0,'h1234,0));
    vecs.push_back(mkv(0,0,0,0,3,4,          1,0,0,1,1,3,'h1234,1,0,'h1234,0));
    vecs.push_back(mkv(0,0,0,1,3,4,          0,1,0,1,0,0,0,0,0,0,0));
    vecs.push_back(mkv(1,3,'h1111,1,3,3,     0,1,0,1,0,0,0,0,0,0,0));
    vecs.push_back(mkv(1,3,'h2222,1,3,3,     1,0,0,1,0,3,'h1111,1,1,'h1111,'h1111));
    vecs.push_back(mkv(0,0,0,1,3,3,          2,0,0,1,0,3,'h1111,1,1,'h2222,'h2222));
    vecs.push_back(mkv(0,0,0,0,3,3,          2,0,0,1,1,3,'h1111,1,1,'h2222,'h2222));
    vecs.push_back(mkv(0,0,0,0,3,3,          1,0,0,1,1,3,'h2222,1,1,'h2222,'h2222));
    vecs.push_back(mkv(0,0,0,0,3,3,          0,1,0,1,0,0,0,0,0,0,0));
    vecs.push_back(mkv(1,0,'hA000,1,7,1,     0,1,0,1,0,0,0,0,0,0,0));
    vecs.push_back(mkv(1,1,'hA001,1,7,1,     1,0,0,1,0,0,'hA000,0,0,0,0));
    vecs.push_back(mkv(1,2,'hA002,1,7,1,     2,0,0,1,0,0,'hA000,0,1,0,'hA001));
    vecs.push_back(mkv(1,1,'hA003,1,7,1,     3,0,0,1,0,0,'hA000,0,1,0,'hA001));
    vecs.push_back(mkv(1,7,'hBEEF,1,7,1,     4,0,1,0,0,0,'hA000,0,1,0,'hA003));
    vecs.push_back(mkv(1,7,'hBEEF,1,7,1,     4,0,1,0,0,0,'hA000,0,1,0,'hA003));
    vecs.push_back(mkv(0,0,0,0,7,1,          4,0,1,0,1,0,'hA000,0,1,0,'hA003));
    vecs.push_back(mkv(0,0,0,0,7,1,          3,0,0,1,1,1,'hA001,0,1,0,'hA003));
    vecs.push_back(mkv(0,0,0,0,7,1,          2,0,0,1,1,2,'hA002,0,1,0,'hA003));
    vecs.push_back(mkv(0,0,0,0,7,1,          1,0,0,1,1,1,'hA003,0,1,0,'hA003));
    vecs.push_back(mkv(0,0,0,0,7,1,          0,1,0,1,0,0,0,0,0,0,0));

    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      enq_valid = vecs[i].ev; enq_address = vecs[i].ea; enq_data = vecs[i].ed;
      rf_hold = vecs[i].hold; query_address_a = vecs[i].qa; query_address_b = vecs[i].qb;
      #1;
      chk($sformatf("vec%0d", i), 64'(pack_out()), 64'(pack_exp(vecs[i])));
    end

    // Back-to-back streaming with the drain running: pointers wrap twice.
    rf_hold = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      enq_valid = 1'b1; enq_address = 3'(i % 8); enq_data = 16'h0100 + 16'(i);
      #1;
      chk($sformatf("stream_count_le1_%0d", i), 64'(count <= 3'd1), 64'd1);
      if (rf_load) begin log_a.push_back(rf_in_address); log_d.push_back(rf_in_data); end
    end
    drained = 1'b0;
    for (int c = 0; c < 20 && !drained; c++) begin
      @(negedge clock);
      enq_valid = 1'b0;
      #1;
      if (rf_load) begin log_a.push_back(rf_in_address); log_d.push_back(rf_in_data); end
      if (empty && !rf_load) drained = 1'b1;
    end
    chk("stream_drained", 64'(drained), 64'd1);
    chk("stream_writes", 64'(log_a.size()), 64'd10);
    for (int j = 0; j < 10 && j < log_a.size(); j++) begin
      chk($sformatf("stream_wr%0d", j), {45'd0, log_a[j], log_d[j]},
          {45'd0, 3'(j % 8), 16'h0100 + 16'(j)});
    end

    // Mid-cycle asynchronous reset with three writes pending.
    rf_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      enq_valid = 1'b1; enq_address = 3'd5; enq_data = 16'h5550 + 16'(i);
    end
    @(negedge clock);
    enq_valid = 1'b0; rf_hold = 1'b0; query_address_a = 3'd5; query_address_b = 3'd5;
    #1;
    chk("prereset_state", {57'd0, count, rf_load, hit_a, hit_b, bypass_data_b[0]},
        {57'd0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0});
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset", 64'(pack_out()),
        64'(pack_exp(mkv(0,0,0,0,5,5, 0,1,0,1,0,0,0,0,0,0,0))));
    @(negedge clock);
    reset = 1'b1;
    rf_hold = 1'b1; enq_valid = 1'b1; enq_address = 3'd6; enq_data = 16'h6666;
    @(negedge clock);
    enq_valid = 1'b0;
    #1;
    chk("post_reset_head", 64'(pack_out()),
        64'(pack_exp(mkv(0,0,0,1,5,5, 1,0,0,1,0,6,'h6666,0,0,0,0))));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/register_writeback_queue.md
Name: register_writeback_queue

Overview:
- Initiator-side companion to the 8x16 register file: buffers pending register writebacks and drains them in order, one per cycle, onto the file's single write port (load / in_address / in_data).
- Exposes hazard lookup on two read addresses so decode can bypass or stall against writes not yet committed to the file.
- Sits between execute/memory writeback and the register file write port.

Parameters:
DEPTH, 4, number of queued writebacks; power of two, >= 2
DATA_WIDTH, 16, register data width
ADDR_WIDTH, 3, register address width (8 registers)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low; clears queue
enq_valid  input  1  producer offers a writeback
enq_ready  output  1  queue can accept this cycle
enq_address  input  ADDR_WIDTH  destination register
enq_data  input  DATA_WIDTH  writeback value
rf_hold  input  1  when high, suppress draining this cycle
rf_load  output  1  write strobe to register file
rf_in_address  output  ADDR_WIDTH  head entry destination
rf_in_data  output  DATA_WIDTH  head entry value
query_address_a  input  ADDR_WIDTH  read port A address under decode
query_address_b  input  ADDR_WIDTH  read port B address under decode
hit_a  output  1  queued write targets query_address_a
hit_b  output  1  queued write targets query_address_b
bypass_data_a  output  DATA_WIDTH  youngest matching queued value for A
bypass_data_b  output  DATA_WIDTH  youngest matching queued value for B
count  output  log2(DEPTH)+1  number of valid entries
empty  output  1  count == 0
full  output  1  count == DEPTH

Behaviour:
- Storage: circular buffer of DEPTH entries {address, data, valid}. Write pointer and read pointer wrap modulo DEPTH. Count is held in a register, not derived from the pointers.
- Enqueue: accepted on a rising edge when enq_valid && enq_ready. enq_ready = !full, with no same-cycle credit from a simultaneous drain.
- Drain: rf_load = !empty && !rf_hold, combinational.
  - rf_in_address and rf_in_data always show the head entry.
  - When the queue is empty they show 0.
  - On an edge with rf_load high, the head pops: read pointer +1, entry invalidated. The register file captures the same edge.
- Latency: an entry accepted on edge N is first visible on rf_* and in hit logic after edge N. There is no fall-through in the same cycle.
- Simultaneous enqueue and pop: count unchanged; both pointers advance.
- Hazard lookup (purely combinational over valid stored entries only; the incoming enq is excluded):
  - hit_x = OR over valid entries of (entry.address == query_address_x).
  - bypass_data_x = data of the youngest matching entry, i.e. closest to the write pointer.
  - bypass_data_x = 0 when hit_x is 0.
  - The entry being popped this cycle still counts as a hit for the whole cycle.
- Ordering: writes reach the register file strictly in acceptance order. Duplicate addresses are all written; none are coalesced.
- Reset (asynchronous, active-low, may arrive mid-operation):
  - Immediately: pointers = 0, count = 0, all valid bits = 0.
  - Outputs take these values: empty=1, full=0, enq_ready=1, rf_load=0, hit_a=hit_b=0, bypass_data_*=0, rf_in_*=0.
  - Queued writes are discarded, not drained.
  - Stored data contents need not be cleared.
- Overflow is impossible by construction (enq_ready low when full). A pop from empty cannot occur (rf_load low when empty).
- rf_hold does not block enqueue.

Test Plan:
1. Assert reset low for 2 cycles, release -> empty=1, count=0, enq_ready=1, rf_load=0, hit_a=hit_b=0.
2. rf_hold=1; enqueue (R3, 0x1234); query_a=3, query_b=4 -> next cycle count=1, hit_a=1, bypass_data_a=0x1234, hit_b=0, rf_load=0, rf_in_address=3.
3. rf_hold=1; enqueue (R3,0x1111) then (R3,0x2222) -> bypass_data_a=0x2222; drop rf_hold -> rf_load high two cycles writing 0x1111 then 0x2222 to R3; count 2->1->0; hit_a clears after the second pop.
4. rf_hold=1; enqueue 4 entries (DEPTH=4) -> full=1, enq_ready=0; a 5th enq_valid (R7, 0xBEEF) is not accepted; count stays 4; after drain, 0xBEEF is never written.
5. rf_hold=0; stream 10 back-to-back enqueues (R0..R7, R0, R1 with data 0x0100+i) -> count never exceeds 1; register file receives all 10 in order across pointer wrap.
6. Queue holds 3 entries; assert reset low mid-cycle -> immediately empty=1, count=0, rf_load=0, hit_a=hit_b=0; after release, the first new enqueue appears at head.
